ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative multi-cycle multiply/divide engine for the RV32M instructions. It sits beside the single-cycle ALU in the execute stage. The execute-stage control hands it one operation at a time through a valid/ready handshake and stalls the pipeline while the unit is busy. The unit sequences a shift-add multiplier and a restoring divider through a small FSM and returns the result with its destination tag.

Parameters:
XLEN, 32, operand and result width in bits
TAG_W, 5, width of the destination-register tag carried with each operation

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  operation offered by the execute stage
req_ready  output  1  unit can accept an operation this cycle
req_funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_opa  input  XLEN  rs1 value
req_opb  input  XLEN  rs2 value
req_tag  input  TAG_W  destination register
flush  input  1  kill any in-flight operation (branch taken or exception)
busy  output  1  an operation is in flight (state != IDLE)
resp_valid  output  1  one-cycle pulse: result is valid
resp_result  output  XLEN  result of the operation
resp_tag  output  TAG_W  tag of the operation being returned

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: IDLE; req_ready=1, busy=0, resp_valid=0, resp_result=0, resp_tag=0. All internal counters and registers are cleared.
- FSM states: IDLE, CALC, DONE.
- Accept occurs on an edge where req_valid & req_ready & ~flush. req_ready = (state==IDLE).
- On accept, the unit latches funct3, tag, and the operand magnitudes:
  - Signed operands (MULH rs1/rs2, MULHSU rs1, DIV/REM both) are converted to absolute value.
  - Result sign is recorded as the XOR of the signs for MUL* and DIV/MULH; for REM it is the dividend sign.
  - MUL uses the low 32 bits of the unsigned product, which is sign-agnostic.
- Normal path: IDLE -> CALC with count=0.
  - Each CALC edge performs one iteration: a 64-bit shift-add step for multiply, or one restoring shift-subtract step for divide.
  - After XLEN iterations (count==XLEN-1 on that edge) the FSM goes to DONE.
- DONE lasts exactly one cycle:
  - resp_valid=1.
  - resp_result is the sign-corrected result: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32] after 64-bit negation if needed; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Next state is IDLE.
- Latency: the accept edge plus 32 CALC edges. resp_valid is high in the cycle after the 32nd CALC edge, which is 33 cycles after the accept edge.
- Fast path: decided at the accept edge, going IDLE -> DONE directly, so resp_valid is high in the cycle right after accept.
  - Divide by zero: DIV/DIVU give quotient 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- resp_result and resp_tag are registered and hold their value until the next DONE. Only resp_valid pulses.
- flush:
  - If asserted in CALC or DONE, the next state is IDLE, no resp_valid is issued, and DONE's output pulse is suppressed combinationally.
  - flush in the same cycle as req_valid blocks the accept.
- rst mid-operation behaves like flush and additionally clears the outputs.
- The unit performs no back-to-back pipelining. A new request can be accepted the cycle after DONE, since req_ready returns when the state returns to IDLE.

Decomposition:
- Shared package (sys_defs): MD_MUL..MD_REMU funct3 constants, the md_state_t enum {IDLE, CALC, DONE}, and the XLEN default.
- One natural sub-module, muldiv_step: the combinational single-iteration datapath (shift-add or shift-subtract on {acc, q}).
- The FSM, counter and sign fix-up stay in the top module.

Test Plan:
- MUL 7 x 6, tag 3 -> resp_valid exactly 33 cycles after accept, result 0x0000002A, resp_tag 3; busy high throughout; req_ready low until the state returns to IDLE.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both one cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, one cycle after accept.
- Start DIVU, assert flush at the 10th CALC cycle -> no resp_valid ever; req_ready=1 the next cycle; an immediate MUL 3 x 3 -> 9 with correct latency. Repeat the sequence with rst instead of flush -> all outputs return to their reset values.
- Hold req_valid with flush=1 in IDLE -> no accept. Issue back-to-back requests -> the second is accepted only on the edge after DONE.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: RV32M funct3 codes, FSM states and operand-sign helpers for the mul/div unit
package ex_muldiv_unit_pkg;
   localparam int DEF_XLEN = 32;
   localparam int DEF_TAG_W = 5;
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;
   typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;
   function automatic logic signed_a(input logic [2:0] f);
      return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction
   function automatic logic signed_b(input logic [2:0] f);
      return f inside {MD_MULH, MD_DIV, MD_REM};
   endfunction
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/response bundle; master = execute stage (req_*, flush), slave = mul/div unit (req_ready, busy, resp_*)
interface ex_muldiv_unit_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
   logic             req_valid, req_ready, flush, busy, resp_valid;
   logic [2:0]       req_funct3;
   logic [XLEN-1:0]  req_opa, req_opb, resp_result;
   logic [TAG_W-1:0] req_tag, resp_tag;
   modport master (output req_valid, req_funct3, req_opa, req_opb, req_tag, flush,
                   input req_ready, busy, resp_valid, resp_result, resp_tag);
   modport slave (input req_valid, req_funct3, req_opa, req_opb, req_tag, flush,
                  output req_ready, busy, resp_valid, resp_result, resp_tag);
endinterface

// File: rtl/ex_muldiv_unit_step.sv
// ex_muldiv_unit_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration on {acc, q}; b is multiplicand/divisor
module ex_muldiv_unit_step #(parameter int XLEN = 32) (
   input  logic            is_div,
   input  logic [XLEN-1:0] acc, q, b,
   output logic [XLEN-1:0] acc_n, q_n
);
   logic [XLEN:0] sum, sh;
   logic          ge;
   always_comb begin
      sum = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
      sh = {acc, q[XLEN-1]};
      ge = sh >= {1'b0, b};
      acc_n = is_div ? (ge ? sh[XLEN-1:0] - b : sh[XLEN-1:0]) : sum[XLEN:1];
      q_n = is_div ? {q[XLEN-2:0], ge} : {sum[0], q[XLEN-1:1]};
   end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide engine; ports clk, rst and md (slave: request, flush, busy, tagged response)
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W
) (
   input logic            clk,
   input logic            rst,
   ex_muldiv_unit_if.slave md
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   md_state_t        state, state_n;
   logic [CW-1:0]    count;
   logic [2:0]       f3;
   logic [TAG_W-1:0] tag_r, tag_o;
   logic             neg, neg_n, na, nb, accept, last, fast, div0, ovf;
   logic [XLEN-1:0]  acc, q, b, acc_n, q_n, ma, mb, fast_res, fix, result;
   ex_muldiv_unit_step #(.XLEN(XLEN)) u_step (
      .is_div(f3[2]),
      .acc(acc),
      .q(q),
      .b(b),
      .acc_n(acc_n),
      .q_n(q_n)
   );
   always_comb begin
      accept = md.req_valid & (state == IDLE) & ~md.flush;
      na = signed_a(md.req_funct3) & md.req_opa[XLEN-1];
      nb = signed_b(md.req_funct3) & md.req_opb[XLEN-1];
      ma = na ? -md.req_opa : md.req_opa;
      mb = nb ? -md.req_opb : md.req_opb;
      neg_n = (md.req_funct3[2] & md.req_funct3[1]) ? na : na ^ nb;
      div0 = md.req_funct3[2] & ~|md.req_opb;
      ovf = (md.req_funct3 inside {MD_DIV, MD_REM}) & (md.req_opa == MIN) & (&md.req_opb);
      fast = div0 | ovf;
      fast_res = div0 ? (md.req_funct3[1] ? md.req_opa : '1) : (md.req_funct3[1] ? '0 : MIN);
      last = count == CW'(XLEN-1);
      // high word of the negated 64-bit product: ~hi plus the carry out of ~lo + 1
      fix = f3[2] ? (f3[1] ? (neg ? -acc_n : acc_n) : (neg ? -q_n : q_n))
          : f3 == MD_MUL ? q_n
          : neg ? ~acc_n + XLEN'(q_n == '0) : acc_n;
      state_n = state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE)
              : state == CALC ? (md.flush ? IDLE : last ? DONE : CALC)
              : IDLE;
      md.req_ready = state == IDLE;
      md.busy = state != IDLE;
      md.resp_valid = (state == DONE) & ~md.flush;
      md.resp_result = result;
      md.resp_tag = tag_o;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         f3 <= '0;
         tag_r <= '0;
         neg <= 1'b0;
         acc <= '0;
         q <= '0;
         b <= '0;
         result <= '0;
         tag_o <= '0;
      end else if (accept) begin
         count <= '0;
         f3 <= md.req_funct3;
         tag_r <= md.req_tag;
         neg <= neg_n;
         acc <= '0;
         q <= ma;
         b <= mb;
         if (fast) begin
            result <= fast_res;
            tag_o <= md.req_tag;
         end
      end else if (state == CALC && !md.flush) begin
         count <= count + 1'b1;
         acc <= acc_n;
         q <= q_n;
         if (last) begin
            result <= fix;
            tag_o <= tag_r;
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against an arithmetic RV32M model
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int passes = 0;
   int pulses = 0;
   int exp_pulses = 0;
   ex_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) md();
   ex_muldiv_unit dut (.clk(clk), .rst(rst), .md(md));
   always #5 clk = ~clk;
   always @(posedge clk) if (md.resp_valid === 1'b1) pulses++;

   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         MD_MUL: begin p = ua * ub; return p[31:0]; end
         MD_MULH: begin p = sa * sb; return p[63:32]; end
         MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
         MD_MULHU: begin p = ua * ub; return p[63:32]; end
         MD_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         MD_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      md.req_valid = 1'b1;
      md.req_funct3 = f;
      md.req_opa = a;
      md.req_opb = b;
      md.req_tag = t;
   endtask

   // entered at the first negedge after the accept edge (cycle 1)
   task automatic wait_resp(output int lat, output int bad);
      lat = 1;
      bad = 0;
      while (md.resp_valid !== 1'b1 && lat < 40) begin
         if (md.busy !== 1'b1 || md.req_ready !== 1'b0) bad++;
         @(negedge clk);
         lat++;
      end
      if (md.busy !== 1'b1 || md.req_ready !== 1'b0) bad++;
   endtask

   task automatic finish_check(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] t, input int lat, input int bad);
      chk({tag, " latency"}, lat, is_fast(f, a, b) ? 1 : 33);
      chk({tag, " result"}, md.resp_result, ref_md(f, a, b));
      chk({tag, " tag"}, {27'd0, md.resp_tag}, {27'd0, t});
      chk({tag, " busy/ready during op"}, bad, 0);
      exp_pulses++;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      int lat, bad;
      drive(f, a, b, t);
      chk({tag, " ready before accept"}, md.req_ready, 1);
      @(negedge clk);
      md.req_valid = 1'b0;
      wait_resp(lat, bad);
      finish_check(tag, f, a, b, t, lat, bad);
      @(negedge clk);
      chk({tag, " idle after done"}, {md.resp_valid, md.busy, md.req_ready}, 3'b001);
      chk({tag, " result holds"}, md.resp_result, ref_md(f, a, b));
   endtask

   initial begin
      int lat, bad;
      logic [2:0] f;
      logic [31:0] a, b;
      md.req_valid = 1'b0;
      md.req_funct3 = '0;
      md.req_opa = '0;
      md.req_opb = '0;
      md.req_tag = '0;
      md.flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {md.req_ready, md.busy, md.resp_valid}, 3'b100);
      chk("reset result", md.resp_result, 0);
      chk("reset tag", {27'd0, md.resp_tag}, 0);
      rst = 1'b0;
      @(negedge clk);

      run_op("MUL 7x6", MD_MUL, 7, 6, 3);
      chk("MUL 7x6 value", md.resp_result, 32'h2A);
      run_op("MULHU", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      chk("MULHU value", md.resp_result, 32'hFFFF_FFFE);
      run_op("MULH", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
      chk("MULH value", md.resp_result, 32'h0);
      run_op("MULHSU", MD_MULHSU, 32'hFFFF_FFFF, 32'h2, 4);
      chk("MULHSU value", md.resp_result, 32'hFFFF_FFFF);
      run_op("DIV -7/2", MD_DIV, -32'sd7, 2, 5);
      chk("DIV value", md.resp_result, 32'hFFFF_FFFD);
      run_op("REM -7/2", MD_REM, -32'sd7, 2, 6);
      chk("REM value", md.resp_result, 32'hFFFF_FFFF);
      run_op("DIVU 100/7", MD_DIVU, 100, 7, 7);
      chk("DIVU value", md.resp_result, 14);
      run_op("REMU 100/7", MD_REMU, 100, 7, 8);
      chk("REMU value", md.resp_result, 2);
      run_op("DIV 5/0", MD_DIV, 5, 0, 9);
      chk("DIV/0 value", md.resp_result, 32'hFFFF_FFFF);
      run_op("REM 5/0", MD_REM, 5, 0, 10);
      chk("REM/0 value", md.resp_result, 5);
      run_op("DIV ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11);
      chk("DIV ovf value", md.resp_result, 32'h8000_0000);
      run_op("REM ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 12);

      drive(MD_DIVU, 1000, 3, 13);
      @(negedge clk);
      md.req_valid = 1'b0;
      repeat (9) @(negedge clk);
      md.flush = 1'b1;
      @(negedge clk);
      md.flush = 1'b0;
      chk("flush idle", {md.resp_valid, md.busy, md.req_ready}, 3'b001);
      run_op("MUL 3x3 after flush", MD_MUL, 3, 3, 14);
      chk("MUL 3x3 flush value", md.resp_result, 9);

      drive(MD_DIVU, 1000, 3, 15);
      @(negedge clk);
      md.req_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid-op flags", {md.resp_valid, md.busy, md.req_ready}, 3'b001);
      chk("rst mid-op result", md.resp_result, 0);
      chk("rst mid-op tag", {27'd0, md.resp_tag}, 0);
      run_op("MUL 3x3 after rst", MD_MUL, 3, 3, 16);
      chk("MUL 3x3 rst value", md.resp_result, 9);

      drive(MD_MUL, 5, 5, 17);
      md.flush = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("flush blocks accept", {md.busy, md.req_ready}, 2'b01);
      end
      md.flush = 1'b0;
      md.req_valid = 1'b0;

      drive(MD_DIVU, 77, 5, 18);
      @(negedge clk);
      drive(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 19);
      wait_resp(lat, bad);
      finish_check("b2b first", MD_DIVU, 77, 5, 18, lat, bad);
      chk("b2b ready low in done", md.req_ready, 0);
      @(negedge clk);
      chk("b2b ready after done", {md.busy, md.req_ready}, 2'b01);
      @(negedge clk);
      chk("b2b second accepted", md.busy, 1);
      md.req_valid = 1'b0;
      wait_resp(lat, bad);
      finish_check("b2b second", MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 19, lat, bad);
      @(negedge clk);

      for (int i = 0; i < 60; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op("random", f, a, b, 5'($urandom));
      end

      chk("response pulse count", pulses, exp_pulses);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
